// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target predictor with 2-bit saturating direction
// counters. A lookup registers its prediction one cycle after PC is
// presented. An update from the execute stage trains the indexed entry.
// Lookups always see the table contents from before that edge's update.
module branch_target_predictor #(
   parameter int   ADDRESS_WIDTH = 32,
   parameter int   ENTRIES       = 16,
   parameter logic HIGH          = 1'b1,
   parameter logic LOW           = 1'b0
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [ADDRESS_WIDTH-1:0] PC,
   input  logic                     LOOKUP_VALID,
   input  logic [ADDRESS_WIDTH-1:0] PC_EXECUTION,
   input  logic [ADDRESS_WIDTH-1:0] PC_PREDICT_LEARN,
   input  logic                     BRANCH_TAKEN,
   input  logic                     PC_PREDICT_LEARN_SELECT,
   output logic [ADDRESS_WIDTH-1:0] PC_PREDICTED,
   output logic                     PC_PREDICTOR_STATUS
);

   localparam int INDEX_WIDTH = $clog2(ENTRIES);
   localparam int TAG_WIDTH   = ADDRESS_WIDTH - INDEX_WIDTH - 2;

   // Table storage, one slot per index
   logic                     r_valid  [ENTRIES];
   logic [TAG_WIDTH-1:0]     r_tag    [ENTRIES];
   logic [ADDRESS_WIDTH-1:0] r_target [ENTRIES];
   logic [1:0]               r_ctr    [ENTRIES];

   logic [ADDRESS_WIDTH-1:0] r_pc_predicted;
   logic                     r_status;

   // Address decomposition for the fetch-side lookup
   logic [INDEX_WIDTH-1:0]   w_lk_idx;
   logic [TAG_WIDTH-1:0]     w_lk_tag;
   logic                     w_lk_hit;
   logic                     w_lk_taken;
   logic [ADDRESS_WIDTH-1:0] w_pc_plus4;

   // Address decomposition for the execute-side update
   logic [INDEX_WIDTH-1:0]   w_up_idx;
   logic [TAG_WIDTH-1:0]     w_up_tag;
   logic                     w_up_hit;

   // The two byte-offset bits never take part in indexing or tagging
   logic                     w_unused_offset_bits;

   assign w_lk_idx   = PC[INDEX_WIDTH+1:2];
   assign w_lk_tag   = PC[ADDRESS_WIDTH-1:INDEX_WIDTH+2];
   assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
   assign w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][1];
   assign w_pc_plus4 = PC + ADDRESS_WIDTH'(4);

   assign w_up_idx   = PC_EXECUTION[INDEX_WIDTH+1:2];
   assign w_up_tag   = PC_EXECUTION[ADDRESS_WIDTH-1:INDEX_WIDTH+2];
   assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

   assign w_unused_offset_bits = ^{PC[1:0], PC_EXECUTION[1:0]};

   // Table training: counter hysteresis on hits, allocation on taken misses
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= LOW;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= 2'b01;
         end
      end else if (PC_PREDICT_LEARN_SELECT == HIGH) begin
         if (w_up_hit) begin
            if (BRANCH_TAKEN == HIGH) begin
               r_target[w_up_idx] <= PC_PREDICT_LEARN;
               if (r_ctr[w_up_idx] != 2'b11) begin
                  r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'b01;
               end
            end else if (r_ctr[w_up_idx] != 2'b00) begin
               r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'b01;
            end
         end else if (BRANCH_TAKEN == HIGH) begin
            // Taken branch not in the table: evict whatever lives here
            r_valid[w_up_idx]  <= HIGH;
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= PC_PREDICT_LEARN;
            r_ctr[w_up_idx]    <= 2'b10;
         end
      end
   end

   // Registered prediction; held while no lookup is requested
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pc_predicted <= '0;
         r_status       <= LOW;
      end else if (LOOKUP_VALID == HIGH) begin
         if (w_lk_taken) begin
            r_pc_predicted <= r_target[w_lk_idx];
            r_status       <= HIGH;
         end else begin
            r_pc_predicted <= w_pc_plus4;
            r_status       <= LOW;
         end
      end
   end

   assign PC_PREDICTED        = r_pc_predicted;
   assign PC_PREDICTOR_STATUS = r_status;

endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: BRANCH_TARGET_PREDICTOR

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32: width of every PC and target bus.
REQ-002 SHALL have parameter ENTRIES, default 16: table depth, a power of two, at least 2; INDEX_WIDTH = log2(ENTRIES).
REQ-003 SHALL have parameters HIGH, default 1'b1, and LOW, default 1'b0: logic level constants.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port PC, input, ADDRESS_WIDTH bits: fetch address to predict.
REQ-007 SHALL have port LOOKUP_VALID, input, 1 bit: PC is valid this cycle.
REQ-008 SHALL have port PC_EXECUTION, input, ADDRESS_WIDTH bits: address of the resolved branch.
REQ-009 SHALL have port PC_PREDICT_LEARN, input, ADDRESS_WIDTH bits: resolved branch target.
REQ-010 SHALL have port BRANCH_TAKEN, input, 1 bit: resolved branch direction.
REQ-011 SHALL have port PC_PREDICT_LEARN_SELECT, input, 1 bit: update strobe for the resolved branch.
REQ-012 SHALL have port PC_PREDICTED, output, ADDRESS_WIDTH bits: registered predicted next fetch address.
REQ-013 SHALL have port PC_PREDICTOR_STATUS, output, 1 bit: registered flag, HIGH = predicted taken.

Function
REQ-014 SHALL hold ENTRIES direct-mapped entries, each with a valid bit, a tag, an ADDRESS_WIDTH target and a 2-bit saturating counter.
REQ-015 SHALL take the index from address bits [INDEX_WIDTH+1:2] and the tag from bits [ADDRESS_WIDTH-1:INDEX_WIDTH+2]; bits [1:0] are ignored.
REQ-016 SHALL define a hit as: entry valid AND stored tag equals the address tag.
REQ-017 SHALL, on a clock edge with LOOKUP_VALID HIGH, register the prediction for PC; latency is exactly one cycle.
REQ-018 SHALL predict taken (PC_PREDICTOR_STATUS HIGH, PC_PREDICTED = stored target) only on a hit with counter bit[1] = 1.
REQ-019 SHALL otherwise predict not taken: PC_PREDICTOR_STATUS LOW, PC_PREDICTED = PC + 4 modulo 2^ADDRESS_WIDTH.
REQ-020 SHALL hold both outputs unchanged while LOOKUP_VALID is LOW.
REQ-021 SHALL, on an update (PC_PREDICT_LEARN_SELECT HIGH) that hits: increment the counter saturating at 2'b11 if BRANCH_TAKEN is HIGH, else decrement it saturating at 2'b00.
REQ-022 SHALL, on a hit update with BRANCH_TAKEN HIGH, also overwrite the target with PC_PREDICT_LEARN.
REQ-023 SHALL, on a taken update that misses (invalid entry or tag mismatch), allocate the entry: valid = 1, new tag, target = PC_PREDICT_LEARN, counter = 2'b10, evicting any previous occupant.
REQ-024 SHALL leave the table unchanged on a not-taken update that misses.
REQ-025 SHALL, when a lookup and an update occur in the same cycle, give the lookup the pre-update table contents (read-before-write), including when both use the same index.
REQ-026 SHALL modify at most one entry per cycle; all other entries are unaffected.

Reset
REQ-027 SHALL, while RST is HIGH and independent of CLK: clear every valid bit, set every counter to 2'b01, and drive PC_PREDICTED to 0 and PC_PREDICTOR_STATUS to LOW.
REQ-028 SHALL ignore lookups and updates while RST is HIGH; a reset asserted mid-operation discards all learned state, and operation resumes on the first rising CLK edge after RST is released.

Verification (ENTRIES=16, ADDRESS_WIDTH=32)
REQ-029 SHALL cover cold miss: reset, then look up PC=0x100 -> next cycle PC_PREDICTED=0x104, STATUS=0.
REQ-030 SHALL cover allocation and hysteresis: a taken update for 0x100 with target 0x200, then look up 0x100 -> 0x200, STATUS=1; two not-taken updates, then look up -> 0x104, STATUS=0.
REQ-031 SHALL cover saturation: allocate 0x100 and apply 3 taken updates (counter 2'b11), then 1 not-taken update, then look up -> 0x200, STATUS=1.
REQ-032 SHALL cover aliasing: with 0x100 learned, a taken update for 0x140 with target 0x300 (same index 0) -> look up 0x100 gives 0x104, STATUS=0; look up 0x140 gives 0x300, STATUS=1.
REQ-033 SHALL cover a simultaneous event: a lookup of 0x100 in the same cycle as its allocating update -> that lookup gives 0x104, STATUS=0; the following lookup gives 0x200, STATUS=1.
REQ-034 SHALL cover wrap-around and reset: look up 0xFFFFFFFC on a miss -> 0x00000000; asserting RST asynchronously after learning 0x100 -> outputs 0 immediately, and a look up of 0x100 after release gives 0x104.
